// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The optional MULT_EARLY_EXIT_EN build uses the same definitions.
package mult_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Iteration counter width; W >= 2 is assumed, the clamp keeps it nonzero.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-add iteration: conditionally add the multiplicand, then shift
// the multiplicand left and the multiplier right.
module shift_add_step #(
  parameter int W = 4
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] a_reg,
  input  logic [W-1:0]   b_reg,
  output logic [2*W-1:0] sum,
  output logic [2*W-1:0] a_nxt,
  output logic [W-1:0]   b_nxt
);

  assign sum   = acc + (b_reg[0] ? a_reg : '0);
  assign a_nxt = a_reg << 1;
  assign b_nxt = b_reg >> 1;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier controller: one partial product per clock,
// one-cycle done pulse. Define MULT_EARLY_EXIT_EN to stop once the multiplier is exhausted.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t         state;
  logic [2*W-1:0] a_reg, acc, sum, a_nxt;
  logic [W-1:0]   b_reg, b_nxt;
  logic [CW-1:0]  cnt;
  logic           last;

  shift_add_step #(.W(W)) u_step (
    .acc   (acc),
    .a_reg (a_reg),
    .b_reg (b_reg),
    .sum   (sum),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt)
  );

`ifdef MULT_EARLY_EXIT_EN
  // Once no multiplier bits remain, further iterations only add zero;
  // B == 0 therefore finishes after a single iteration.
  assign last = (cnt == CNT_LAST) || (b_nxt == '0);
`else
  assign last = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= {{W{1'b0}}, A};
            b_reg <= B;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          done <= 1'b0;
        end
        CALC: begin
          acc   <= sum;
          a_reg <= a_nxt;
          b_reg <= b_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            P     <= sum;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: products queued at issue, checked on done.
// Latency expectations follow the MULT_EARLY_EXIT_EN setting of the build.
module tb_mult_seq_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           busy, done;
  logic [2*W-1:0] P;

  logic [2*W-1:0] sbq[$];
  int n_chk = 0, n_fail = 0, n_done = 0, n_exp = 0;

  mult_seq_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      n_done++;
      chk("busy_with_done", 32'(busy), 0);
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else chk("product", 32'(P), 32'(sbq.pop_front()));
    end
  end

  function automatic int exp_lat(input logic [W-1:0] b);
    int l;
`ifdef MULT_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
`else
    l = W;
`endif
    return l;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    A = a;
    B = b;
    start = 1'b1;
    sbq.push_back(ea * eb);
    n_exp++;
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, nb;
    @(negedge clk);
    issue(a, b);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    chk("latency", lat, exp_lat(b));
    chk("busy_cycles", nb, exp_lat(b));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int lat, nb, d0;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("reset_P", 32'(P), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    reset = 1'b1;

    run(5, 0);
    run(15, 15);
    repeat (3) @(negedge clk);
    chk("P_hold", 32'(P), 225);
    run(7, 2);

    // back-to-back: start held high through DONE
    @(negedge clk);
    issue(13, 11);
    @(negedge clk);
    wait_done(lat, nb);
    chk("b2b_first_lat", lat, exp_lat(11));
    issue(3, 5);
    @(negedge clk);
    chk("b2b_no_idle", 32'(busy), 1);
    start = 1'b0;
    wait_done(lat, nb);
    chk("b2b_second_lat", lat, exp_lat(5));

    // start pulse during CALC must be ignored
    @(negedge clk);
    d0 = n_done;
    issue(9, 6);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 1; B = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 0; B = 0;
    wait_done(lat, nb);
    chk("ignored_lat", lat + 2, exp_lat(6));
    repeat (8) @(negedge clk);
    chk("ignored_one_done", n_done - d0, 1);

    // reset mid-operation discards the result
    @(negedge clk);
    issue(12, 10);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    sbq.delete();
    n_exp--;
    d0 = n_done;
    @(negedge clk);
    chk("midreset_P", 32'(P), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("midreset_no_done", n_done - d0, 0);
    chk("midreset_P_idle", 32'(P), 0);
    run(2, 3);

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      run(ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("done_count", n_done, n_exp);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
